// File: rtl/stream_fifo_flushable.sv
// Elastic valid/ready buffer with synchronous flush, placed ahead of the arbiter.
// Registered outputs only: no fall-through, no combinational ready path from the pop side.
module stream_fifo_flushable #(
    parameter type DATA_T = logic,
    parameter int  DEPTH  = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  DATA_T                    inp_data_i,
    input  logic                     inp_valid_i,
    output logic                     inp_ready_o,
    output DATA_T                    oup_data_o,
    output logic                     oup_valid_o,
    input  logic                     oup_ready_i,
    output logic [$clog2(DEPTH+1)-1:0] usage_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    if (DEPTH < 1) begin : g_bad_depth
        $fatal(1, "stream_fifo_flushable: DEPTH must be >= 1");
    end

    DATA_T           storage [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic            push;
    logic            pop;

    assign full_o      = (count == CW'(DEPTH));
    assign empty_o     = (count == '0);
    assign usage_o     = count;
    assign inp_ready_o = !full_o && !flush_i;
    assign oup_valid_o = !empty_o && !flush_i;
    assign oup_data_o  = storage[rd_ptr];
    assign push        = inp_valid_i && inp_ready_o;
    assign pop         = oup_valid_o && oup_ready_i;

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Payload storage; deliberately untouched by reset and flush.
    always_ff @(posedge clk_i) begin
        if (push) begin
            storage[wr_ptr] <= inp_data_i;
        end
    end

    // Pointers and occupancy; reset beats flush, flush beats handshakes.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wrap_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= wrap_inc(rd_ptr);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    a_no_push_full: assert property (
        @(posedge clk_i) disable iff (rst_i) !(push && full_o));
    a_usage_bound: assert property (
        @(posedge clk_i) disable iff (rst_i) (count <= CW'(DEPTH)));

endmodule
